// File: rtl/vend_pkg.sv
// Shared types for the vending credit controller: FSM states, coin codes and coin values.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE,
    REFUND
  } state_e;

  typedef enum logic [1:0] {
    COIN_5   = 2'b00,
    COIN_10  = 2'b01,
    COIN_20  = 2'b10,
    COIN_INV = 2'b11
  } coin_code_e;

  function automatic logic [7:0] coin_value(input coin_code_e code);
    case (code)
      COIN_5:  return 8'd5;
      COIN_10: return 8'd10;
      COIN_20: return 8'd20;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_coin_decode.sv
// Maps a coin code plus the current credit to the coin's value and whether it may be credited.
module vend_coin_decode
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = 6,
  parameter int MAX_CREDIT = 40
) (
  input  coin_code_e          code,
  input  logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] value,
  output logic                accept
);

  logic [CREDIT_W:0] sum;

  // One extra bit so a near-full register cannot wrap and slip past the limit check.
  assign value  = CREDIT_W'(coin_value(code));
  assign sum    = {1'b0, credit} + {1'b0, value};
  assign accept = (code != COIN_INV) && (sum <= (CREDIT_W+1)'(MAX_CREDIT));

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending transaction controller: collects coin credit, requests a vend, then pays change.
// Define VEND_CANCEL_EN to let a customer cancel during collection and get a full refund.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE      = 20,
  parameter int COIN_UNIT  = 5,
  parameter int MAX_CREDIT = 40,
  parameter int CREDIT_W   = 6
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                coin_valid_i,
  input  logic [1:0]          coin_i,
  input  logic                cancel_i,
  input  logic                vend_ack_i,
  input  logic                change_ready_i,
  output logic                coin_reject_o,
  output logic                vend_valid_o,
  output logic                change_valid_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                busy_o
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(COIN_UNIT);

  state_e              state, state_n;
  coin_code_e          coin_code;
  logic [CREDIT_W-1:0] credit_n, coin_val;
  logic                coin_ok, reject_n, cancel_hit;

  assign coin_code = coin_code_e'(coin_i);

`ifdef VEND_CANCEL_EN
  assign cancel_hit = cancel_i;
`else
  logic unused_cancel;
  assign unused_cancel = cancel_i;
  assign cancel_hit    = 1'b0;
`endif

  vend_coin_decode #(
    .CREDIT_W  (CREDIT_W),
    .MAX_CREDIT(MAX_CREDIT)
  ) u_decode (
    .code  (coin_code),
    .credit(credit_o),
    .value (coin_val),
    .accept(coin_ok)
  );

  // In COLLECT the price check outranks a coin, so a coin never lands in the cycle that decides to vend.
  always_comb begin
    state_n  = state;
    credit_n = credit_o;
    reject_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (coin_valid_i) begin
          if (coin_ok) begin
            credit_n = credit_o + coin_val;
            state_n  = COLLECT;
          end else begin
            reject_n = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (cancel_hit) begin
          state_n  = REFUND;
          reject_n = coin_valid_i;
        end else if (credit_o >= PRICE_C) begin
          state_n  = VEND;
          reject_n = coin_valid_i;
        end else if (coin_valid_i) begin
          if (coin_ok) credit_n = credit_o + coin_val;
          else         reject_n = 1'b1;
        end
      end
      VEND: begin
        reject_n = coin_valid_i;
        if (vend_ack_i) begin
          credit_n = credit_o - PRICE_C;
          state_n  = (credit_o == PRICE_C) ? IDLE : CHANGE;
        end
      end
      CHANGE, REFUND: begin
        reject_n = coin_valid_i;
        if (change_ready_i) begin
          credit_n = credit_o - UNIT_C;
          if (credit_o == UNIT_C) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      credit_o       <= '0;
      coin_reject_o  <= 1'b0;
      vend_valid_o   <= 1'b0;
      change_valid_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state          <= state_n;
      credit_o       <= credit_n;
      coin_reject_o  <= reject_n;
      vend_valid_o   <= (state_n == VEND);
      change_valid_o <= (state_n == CHANGE) || (state_n == REFUND);
      busy_o         <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Self-checking bench for vend_credit_ctrl: directed vector table, corner sequences, randomized model run.
// A second instance with PRICE=MAX_CREDIT=40 exercises the credit-overflow reject.
module tb_vend_credit_ctrl;

  localparam int PRICE      = 20;
  localparam int COIN_UNIT  = 5;
  localparam int MAX_CREDIT = 40;
  localparam int CREDIT_W   = 6;
`ifdef VEND_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic coin_valid = 1'b0, cancel = 1'b0, ack = 1'b0, ready = 1'b0;
  logic [1:0] coin = 2'b00;
  logic coin_reject, vend_valid, change_valid, busy;
  logic [CREDIT_W-1:0] credit;

  logic b_coin_valid = 1'b0;
  logic [1:0] b_coin = 2'b00;
  logic b_reject, b_vend, b_change, b_busy;
  logic [CREDIT_W-1:0] b_credit;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  vend_credit_ctrl #(
    .PRICE(PRICE), .COIN_UNIT(COIN_UNIT), .MAX_CREDIT(MAX_CREDIT), .CREDIT_W(CREDIT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .coin_valid_i(coin_valid), .coin_i(coin), .cancel_i(cancel),
    .vend_ack_i(ack), .change_ready_i(ready), .coin_reject_o(coin_reject),
    .vend_valid_o(vend_valid), .change_valid_o(change_valid), .credit_o(credit), .busy_o(busy)
  );

  vend_credit_ctrl #(
    .PRICE(40), .COIN_UNIT(5), .MAX_CREDIT(40), .CREDIT_W(CREDIT_W)
  ) dut_full (
    .clk_i(clk), .rst_ni(rst_n), .coin_valid_i(b_coin_valid), .coin_i(b_coin), .cancel_i(1'b0),
    .vend_ack_i(1'b0), .change_ready_i(1'b0), .coin_reject_o(b_reject),
    .vend_valid_o(b_vend), .change_valid_o(b_change), .credit_o(b_credit), .busy_o(b_busy)
  );

  typedef struct {
    logic       cv;
    logic [1:0] code;
    logic       ack;
    logic       ready;
    logic       exp_reject;
    logic       exp_vend;
    logic       exp_change;
    logic       exp_busy;
    int         exp_credit;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: credit in cents and the transaction phase by name.
  int    m_credit;
  string m_phase;
  bit    m_reject;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input bit rej, input bit vend, input bit chg,
                          input bit bsy, input int cred);
    checkOutput({tag, " coin_reject"}, int'(coin_reject), int'(rej));
    checkOutput({tag, " vend_valid"}, int'(vend_valid), int'(vend));
    checkOutput({tag, " change_valid"}, int'(change_valid), int'(chg));
    checkOutput({tag, " busy"}, int'(busy), int'(bsy));
    checkOutput({tag, " credit"}, int'(credit), cred);
  endtask

  task automatic applyStimulus(input logic cv, input logic [1:0] code, input logic cn,
                               input logic ak, input logic rd);
    coin_valid = cv;
    coin       = code;
    cancel     = cn;
    ack        = ak;
    ready      = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic cv, input logic [1:0] code, input logic ak, input logic rd,
                        input logic rej, input logic vend, input logic chg, input logic bsy,
                        input int cred);
    vec_t v;
    v.cv = cv; v.code = code; v.ack = ak; v.ready = rd;
    v.exp_reject = rej; v.exp_vend = vend; v.exp_change = chg; v.exp_busy = bsy;
    v.exp_credit = cred;
    vecs.push_back(v);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    coin_valid = 1'b0; cancel = 1'b0; ack = 1'b0; ready = 1'b0;
    b_coin_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_credit = 0;
    m_phase  = "IDLE";
    m_reject = 1'b0;
  endtask

  function automatic int centsOf(input logic [1:0] code);
    case (code)
      2'b00:   return 5;
      2'b01:   return 10;
      2'b10:   return 20;
      default: return -1;
    endcase
  endfunction

  // Transaction rules applied to one clock edge's inputs.
  task automatic modelStep(input bit cv, input logic [1:0] code, input bit cn, input bit ak,
                           input bit rd);
    int  val;
    bit  fits;
    val  = centsOf(code);
    fits = (val > 0) && (m_credit + val <= MAX_CREDIT);
    m_reject = 1'b0;
    if (m_phase == "IDLE") begin
      if (cv && fits) begin
        m_credit += val;
        m_phase = "COLLECT";
      end else if (cv) begin
        m_reject = 1'b1;
      end
    end else if (m_phase == "COLLECT") begin
      if (CANCEL_EN && cn) begin
        m_phase  = "REFUND";
        m_reject = cv;
      end else if (m_credit >= PRICE) begin
        m_phase  = "VEND";
        m_reject = cv;
      end else if (cv) begin
        if (fits) m_credit += val;
        else      m_reject = 1'b1;
      end
    end else if (m_phase == "VEND") begin
      m_reject = cv;
      if (ak) begin
        m_credit -= PRICE;
        m_phase = (m_credit == 0) ? "IDLE" : "CHANGE";
      end
    end else begin
      m_reject = cv;
      if (rd) begin
        m_credit -= COIN_UNIT;
        if (m_credit == 0) m_phase = "IDLE";
      end
    end
  endtask

  initial begin
    $display("[TB] start, cancel feature %0d", CANCEL_EN);
    doReset();
    checkAll("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("full reset credit", int'(b_credit), 0);

    // Exact price, overpay with one change coin, invalid code, reject during vend, backpressure.
    addVec(1, 2'b10, 0, 0, 0, 0, 0, 1, 20);
    addVec(0, 2'b00, 0, 0, 0, 1, 0, 1, 20);
    addVec(0, 2'b00, 1, 0, 0, 0, 0, 0, 0);
    addVec(1, 2'b00, 0, 0, 0, 0, 0, 1, 5);
    addVec(1, 2'b01, 0, 0, 0, 0, 0, 1, 15);
    addVec(1, 2'b01, 0, 0, 0, 0, 0, 1, 25);
    addVec(0, 2'b00, 0, 0, 0, 1, 0, 1, 25);
    addVec(0, 2'b00, 1, 0, 0, 0, 1, 1, 5);
    addVec(0, 2'b00, 0, 1, 0, 0, 0, 0, 0);
    addVec(1, 2'b11, 0, 0, 1, 0, 0, 0, 0);
    addVec(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 2'b01, 0, 0, 0, 0, 0, 1, 10);
    addVec(0, 2'b00, 0, 0, 0, 0, 0, 1, 10);
    addVec(1, 2'b10, 0, 0, 0, 0, 0, 1, 30);
    addVec(0, 2'b00, 0, 0, 0, 1, 0, 1, 30);
    addVec(1, 2'b01, 0, 0, 1, 1, 0, 1, 30);
    addVec(0, 2'b00, 1, 0, 0, 0, 1, 1, 10);
    addVec(0, 2'b00, 0, 0, 0, 0, 1, 1, 10);
    addVec(0, 2'b00, 0, 0, 0, 0, 1, 1, 10);
    addVec(0, 2'b00, 0, 0, 0, 0, 1, 1, 10);
    addVec(0, 2'b00, 0, 1, 0, 0, 1, 1, 5);
    addVec(0, 2'b00, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].cv, vecs[i].code, 1'b0, vecs[i].ack, vecs[i].ready);
      checkAll($sformatf("vec%0d", i), vecs[i].exp_reject, vecs[i].exp_vend,
               vecs[i].exp_change, vecs[i].exp_busy, vecs[i].exp_credit);
    end

    // Cancel with 15 cents in COLLECT.
    applyStimulus(1, 2'b01, 0, 0, 0);
    applyStimulus(1, 2'b00, 0, 0, 0);
    applyStimulus(0, 2'b00, 0, 0, 0);
    checkAll("pre-cancel", 0, 0, 0, 1, 15);
    applyStimulus(0, 2'b00, 1, 0, 0);
    if (CANCEL_EN) begin
      checkAll("cancel", 0, 0, 1, 1, 15);
      applyStimulus(0, 2'b00, 0, 0, 1);
      checkAll("refund1", 0, 0, 1, 1, 10);
      applyStimulus(0, 2'b00, 0, 0, 1);
      checkAll("refund2", 0, 0, 1, 1, 5);
      applyStimulus(0, 2'b00, 0, 0, 1);
      checkAll("refund3", 0, 0, 0, 0, 0);
    end else begin
      checkAll("cancel ignored", 0, 0, 0, 1, 15);
      applyStimulus(1, 2'b00, 0, 0, 0);
      checkAll("cancel topup", 0, 0, 0, 1, 20);
      applyStimulus(0, 2'b00, 0, 0, 0);
      applyStimulus(0, 2'b00, 0, 1, 0);
      checkAll("cancel vend done", 0, 0, 0, 0, 0);
    end

    // Asynchronous reset in the middle of change dispensing.
    applyStimulus(1, 2'b01, 0, 0, 0);
    applyStimulus(1, 2'b10, 0, 0, 0);
    applyStimulus(0, 2'b00, 0, 0, 0);
    applyStimulus(0, 2'b00, 0, 1, 0);
    checkAll("pre-reset change", 0, 0, 1, 1, 10);
    ack = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checkAll("async reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 2'b00, 0, 0, 0);
    checkAll("after reset coin", 0, 0, 0, 1, 5);

    // Overflow reject on the PRICE=40 instance.
    doReset();
    b_coin_valid = 1'b1; b_coin = 2'b10;
    applyStimulus(0, 2'b00, 0, 0, 0);
    checkOutput("full credit 20", int'(b_credit), 20);
    b_coin = 2'b01;
    applyStimulus(0, 2'b00, 0, 0, 0);
    checkOutput("full credit 30", int'(b_credit), 30);
    b_coin = 2'b10;
    applyStimulus(0, 2'b00, 0, 0, 0);
    checkOutput("full overflow reject", int'(b_reject), 1);
    checkOutput("full overflow credit", int'(b_credit), 30);
    checkOutput("full overflow busy", int'(b_busy), 1);
    b_coin = 2'b01;
    applyStimulus(0, 2'b00, 0, 0, 0);
    checkOutput("full fill reject", int'(b_reject), 0);
    checkOutput("full fill credit", int'(b_credit), 40);
    b_coin_valid = 1'b0;
    applyStimulus(0, 2'b00, 0, 0, 0);
    checkOutput("full vend", int'(b_vend), 1);

    // Randomized run against the reference model.
    doReset();
    for (int n = 0; n < 1500; n++) begin
      logic       cv, cn, ak, rd;
      logic [1:0] code;
      cv   = ($urandom_range(0, 9) < 4);
      code = 2'($urandom_range(0, 3));
      cn   = ($urandom_range(0, 9) == 0);
      ak   = ($urandom_range(0, 2) == 0);
      rd   = ($urandom_range(0, 1) == 0);
      applyStimulus(cv, code, cn, ak, rd);
      modelStep(cv, code, cn, ak, rd);
      checkAll($sformatf("rand%0d", n), m_reject, m_phase == "VEND",
               (m_phase == "CHANGE") || (m_phase == "REFUND"), m_phase != "IDLE", m_credit);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
